// File: rtl/gb_apu_noise_ctrl_if.sv
// CPU register bus for the noise channel control block (NR41..NR44).
// Strobes, address and write data come from the CPU side; read data returns to it.
interface gb_apu_noise_ctrl_if;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;

    // A strobe is valid for exactly the one cycle it is high; the slave
    // always accepts it, so there is no ready signal. Read data is
    // registered and appears the cycle after cpu_rd.
    modport master (
        output cpu_wr,
        output cpu_rd,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_wr,
        input  cpu_rd,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_rdata
    );
endinterface

// File: rtl/gb_apu_noise_ctrl.sv
// Game Boy APU noise channel control: NR41..NR44 registers, trigger pulse and frame sequencer.
// Define GB_APU_NOISE_READBACK_EN to build the CPU readback path; otherwise cpu_rdata is 0xFF.
module gb_apu_noise_ctrl (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      div_tick,
    input  logic                      apu_power,
    gb_apu_noise_ctrl_if.slave        bus,
    output logic [5:0]                length,
    output logic [3:0]                initial_volume,
    output logic                      envelope_increasing,
    output logic [2:0]                num_envelope_sweeps,
    output logic [3:0]                shift_clock_freq,
    output logic                      counter_width,
    output logic [2:0]                freq_dividing_ratio,
    output logic                      single,
    output logic                      start,
    output logic                      clk_length_ctr,
    output logic                      clk_vol_env,
    output logic [2:0]                frame_step,
    output logic                      dac_enable,
    output logic [1:0]                trig_state
);

    localparam logic [7:0] ADDR_NR41 = 8'h20;
    localparam logic [7:0] ADDR_NR42 = 8'h21;
    localparam logic [7:0] ADDR_NR43 = 8'h22;
    localparam logic [7:0] ADDR_NR44 = 8'h23;

    typedef enum logic [1:0] {
        TRIG_IDLE    = 2'd0,
        TRIG_PULSE   = 2'd1,
        TRIG_PENDING = 2'd2
    } trig_state_t;

    trig_state_t state_q;
    logic [5:0]  nr41_q;
    logic [7:0]  nr42_q;
    logic [7:0]  nr43_q;
    logic        single_q;
    logic [2:0]  step_q;
    logic        start_q;
    logic        len_tick_q;
    logic        env_tick_q;

    logic        wr_en;
    logic [7:0]  nr42_next;
    logic        dac_next;
    logic        trig_req;
    logic [2:0]  step_next;

    assign wr_en     = bus.cpu_wr && apu_power;
    // The DAC check must see an NR42 value written in the same cycle.
    assign nr42_next = (wr_en && bus.cpu_addr == ADDR_NR42) ? bus.cpu_wdata : nr42_q;
    assign dac_next  = |nr42_next[7:3];
    assign trig_req  = wr_en && (bus.cpu_addr == ADDR_NR44) && bus.cpu_wdata[7] && dac_next;
    assign step_next = step_q + 3'd1;

    always_ff @(posedge clk) begin
        if (reset || !apu_power) begin
            nr41_q     <= 6'd0;
            nr42_q     <= 8'd0;
            nr43_q     <= 8'd0;
            single_q   <= 1'b0;
            step_q     <= 3'd0;
            len_tick_q <= 1'b0;
            env_tick_q <= 1'b0;
            start_q    <= 1'b0;
            state_q    <= TRIG_IDLE;
        end else begin
            if (wr_en) begin
                case (bus.cpu_addr)
                    ADDR_NR41: nr41_q   <= bus.cpu_wdata[5:0];
                    ADDR_NR42: nr42_q   <= bus.cpu_wdata;
                    ADDR_NR43: nr43_q   <= bus.cpu_wdata;
                    ADDR_NR44: single_q <= bus.cpu_wdata[6];
                    default:   ;
                endcase
            end

            // Tick pulses are registered, so they appear the cycle after div_tick.
            if (div_tick) begin
                step_q     <= step_next;
                len_tick_q <= ~step_next[0];
                env_tick_q <= (step_next == 3'd7);
            end else begin
                len_tick_q <= 1'b0;
                env_tick_q <= 1'b0;
            end

            // A request that lands during the pulse is deferred one gap cycle;
            // requests seen while already deferred fold into that one pulse.
            case (state_q)
                TRIG_IDLE: begin
                    if (trig_req) begin
                        state_q <= TRIG_PULSE;
                        start_q <= 1'b1;
                    end else begin
                        start_q <= 1'b0;
                    end
                end
                TRIG_PULSE: begin
                    start_q <= 1'b0;
                    state_q <= trig_req ? TRIG_PENDING : TRIG_IDLE;
                end
                TRIG_PENDING: begin
                    start_q <= 1'b1;
                    state_q <= TRIG_PULSE;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= TRIG_IDLE;
                end
            endcase
        end
    end

`ifdef GB_APU_NOISE_READBACK_EN
    logic [7:0] rdata_q;

    // Reads sample the registers before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 8'hFF;
        end else if (bus.cpu_rd) begin
            case (bus.cpu_addr)
                ADDR_NR41: rdata_q <= 8'hFF;
                ADDR_NR42: rdata_q <= nr42_q;
                ADDR_NR43: rdata_q <= nr43_q;
                ADDR_NR44: rdata_q <= {1'b1, single_q, 6'h3F};
                default:   rdata_q <= 8'hFF;
            endcase
        end
    end

    assign bus.cpu_rdata = rdata_q;
`else
    logic unused_rd;
    assign unused_rd     = bus.cpu_rd;
    assign bus.cpu_rdata = 8'hFF;
`endif

    assign length              = nr41_q;
    assign initial_volume      = nr42_q[7:4];
    assign envelope_increasing = nr42_q[3];
    assign num_envelope_sweeps = nr42_q[2:0];
    assign shift_clock_freq    = nr43_q[7:4];
    assign counter_width       = nr43_q[3];
    assign freq_dividing_ratio = nr43_q[2:0];
    assign single              = single_q;
    assign start               = start_q;
    assign clk_length_ctr      = len_tick_q;
    assign clk_vol_env         = env_tick_q;
    assign frame_step          = step_q;
    assign dac_enable          = |nr42_q[7:3];
    assign trig_state          = state_q;

endmodule

// File: doc/gb_apu_noise_ctrl.md
GB_APU_NOISE_CTRL -- requirements
Module: gb_apu_noise_ctrl

Interface
REQ-001 clk  input  1  CPU clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 div_tick  input  1  one-cycle pulse at 512 Hz; advances the frame sequencer.
REQ-004 apu_power  input  1  NR52 bit 7; 0 = APU powered off.
REQ-005 cpu_wr / cpu_rd  input  1 each  one-cycle bus write / read strobes.
REQ-006 cpu_addr  input  8  low byte of the I/O address; 0x20..0x23 = NR41..NR44.
REQ-007 cpu_wdata  input  8  write data.
REQ-008 cpu_rdata  output  8  registered read data.
REQ-009 length  output  6  NR41[5:0].
REQ-010 initial_volume  output  4  NR42[7:4]; envelope_increasing  output  1  NR42[3]; num_envelope_sweeps  output  3  NR42[2:0].
REQ-011 shift_clock_freq  output  4  NR43[7:4]; counter_width  output  1  NR43[3]; freq_dividing_ratio  output  3  NR43[2:0].
REQ-012 single  output  1  NR44[6].
REQ-013 start  output  1  trigger pulse to the noise channel.
REQ-014 clk_length_ctr / clk_vol_env  output  1 each  one-cycle length / envelope tick pulses.
REQ-015 frame_step  output  3  current frame-sequencer step.
REQ-016 dac_enable  output  1  high when NR42[7:3] != 0.

Function
REQ-017 Register writes: cpu_wr with address 0x20..0x23 and apu_power=1 updates the addressed register on that edge; other addresses are ignored.
REQ-018 NR44 write with cpu_wdata[7]=1 requests a trigger; bit 7 is not stored; bit 6 is stored as single.
REQ-019 A trigger request with dac_enable=1 (using NR42 after any same-cycle write) drives start=1 for exactly one cycle, starting the cycle after the write.
REQ-020 A trigger request with dac_enable=0 is discarded; start stays 0.
REQ-021 start is never high on two consecutive cycles; a trigger requested while start=1 sets a pending flag; start deasserts for one cycle, then pulses once; further requests while pending are merged.
REQ-022 Frame sequencer: 3-bit step counter advances by 1 on each div_tick and wraps 7->0.
REQ-023 On the div_tick that moves the step into 0, 2, 4 or 6, clk_length_ctr pulses for one cycle on the following cycle.
REQ-024 On the div_tick that moves the step into 7, clk_vol_env pulses for one cycle on the following cycle.
REQ-025 clk_length_ctr and clk_vol_env are low at all other times; they are never high together.
REQ-026 apu_power=0: all NR4x registers, the step counter, the pending flag, start and the tick pulses are held at 0; div_tick and writes are ignored.
REQ-027 apu_power rising: sequencer resumes from step 0; the first div_tick moves it to step 1.
REQ-028 A write and a read to the same address in one cycle: cpu_rdata returns the pre-write value.

Reset
REQ-029 While reset=1, every register and the step counter are 0, and start, clk_length_ctr, clk_vol_env and dac_enable are 0.
REQ-030 While reset=1, cpu_rdata = 0xFF, and all register outputs are 0.
REQ-031 reset has priority over all writes, ticks and pending triggers; a pending trigger is dropped.

Configuration
REQ-032 Macro GB_APU_NOISE_READBACK_EN, when defined: cpu_rd to 0x20..0x23 updates cpu_rdata on the next cycle as follows.
 - NR41 reads 0xFF.
 - NR42 and NR43 read their stored values.
 - NR44 reads {1, single, 6'b111111}.
 - Other addresses read 0xFF.
REQ-033 When GB_APU_NOISE_READBACK_EN is undefined, no readback logic is built and cpu_rdata is constant 0xFF.

Verification
REQ-034 Write NR42=0xF3, then NR44=0x80 -> start high for exactly 1 cycle, one cycle after the write; initial_volume=0xF, num_envelope_sweeps=3.
REQ-035 Write NR42=0x07, then NR44=0xC0 -> no start pulse, dac_enable=0, single=1.
REQ-036 Apply 16 div_ticks from reset -> 8 clk_length_ctr pulses, 2 clk_vol_env pulses, and frame_step ends at 0.
REQ-037 NR44=0x80 written on two consecutive cycles (DAC on) -> start sequence is 1,0,1 over three cycles.
REQ-038 Write NR43=0x5A, then drop apu_power for 1 cycle -> shift_clock_freq=0, freq_dividing_ratio=0, frame_step=0; with readback, NR43 reads 0x00.
REQ-039 With the macro defined, write NR44=0x40, then read 0x23 -> cpu_rdata=0xFF; read 0x22 after NR43=0x5A -> 0x5A.
